mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width.
REQ-002 SHALL have parameter CNT_W, default 32, width of the grant counters.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ireq_valid  in  1  instruction-fetch read request.
REQ-006 ireq_ready  out  1  fetch command accepted this cycle.
REQ-007 ireq_addr  in  XLEN  fetch address.
REQ-008 iresp_valid  out  1  fetch read data valid, one-cycle pulse.
REQ-009 iresp_rdata  out  XLEN  fetch read data.
REQ-010 dreq_valid  in  1  data-stage request (load or store).
REQ-011 dreq_ready  out  1  data command accepted this cycle.
REQ-012 dreq_wen  in  1  1 = store, 0 = load.
REQ-013 dreq_addr, dreq_wdata  in  XLEN each  data address and store data.
REQ-014 dreq_wmask  in  2  access size (MemSize encoding).
REQ-015 dresp_valid  out  1  load data returned or store complete, one-cycle pulse.
REQ-016 dresp_rdata  out  XLEN  load data.
REQ-017 mreq_valid, mreq_wen, mreq_addr, mreq_wdata, mreq_wmask  out  1/1/XLEN/XLEN/2  shared memory command.
REQ-018 mreq_ready  in  1  memory accepts command.
REQ-019 mresp_valid  in  1, mresp_rdata  in  XLEN  memory response.
REQ-020 err_unexpected_resp  out  1  sticky: a response arrived with no transaction outstanding.
REQ-021 icount, dcount  out  CNT_W  accepted-command counters per port.

Function
REQ-022 SHALL allow exactly one outstanding memory transaction; states IDLE, WAIT_I, WAIT_D.
REQ-023 In IDLE, if exactly one requester is valid, that one SHALL be selected; if both, the one not granted last SHALL be selected (round-robin via last_grant bit).
REQ-024 In IDLE, mreq_* SHALL combinationally mirror the selected requester, mreq_valid = selected valid; no requester valid -> mreq_valid=0, mreq_wen=0.
REQ-025 ready SHALL be returned only to the selected requester: ireq_ready/dreq_ready = selected & mreq_ready & IDLE.
REQ-026 Selection is NOT locked before acceptance: a requester may drop valid (trap flush) before ready, and arbitration SHALL re-evaluate each IDLE cycle.
REQ-027 On mreq_valid & mreq_ready in IDLE: state -> WAIT_I or WAIT_D, last_grant updated, owning counter +1 (wraps at 2^CNT_W).
REQ-028 In WAIT_x, mreq_valid SHALL be 0 and both readies 0.
REQ-029 In WAIT_x, mresp_valid SHALL produce iresp_valid or dresp_valid (owner only) the same cycle, rdata passed through, state -> IDLE.
REQ-030 A request present in the cycle of the response SHALL be arbitrated the following cycle (one-cycle turnaround minimum).
REQ-031 mresp_valid in IDLE SHALL be dropped and SHALL set err_unexpected_resp until reset.
REQ-032 iresp_valid/dresp_valid SHALL never both be 1.

Reset
REQ-033 rst_n low SHALL force, immediately: state IDLE, last_grant = I (data wins first tie), icount=dcount=0, err_unexpected_resp=0; all valid/ready outputs 0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding transaction; its late response then sets err_unexpected_resp.

Structure
REQ-035 Arbiter state enum and grant-owner type SHALL live in the shared package beside DReq/DResp/MemSize; XLEN from basicparams.
REQ-036 Single module; no sub-modules.

Verification
REQ-037 Only dreq load 0x100, mreq_ready=1, mresp 2 cycles later rdata=0xDEADBEEF -> dreq_ready cycle 0, dresp_valid cycle 2 with 0xDEADBEEF, dcount=1.
REQ-038 Both valid continuously from reset, memory 1-cycle response -> grants D,I,D,I alternate; after 4 transactions icount=dcount=2.
REQ-039 Both valid, mreq_ready held 0 for 5 cycles, then dreq_valid dropped -> no dreq_ready, I granted once ready rises.
REQ-040 mresp_valid pulsed in IDLE -> no iresp/dresp pulse, err_unexpected_resp=1 until rst_n low.
REQ-041 rst_n low during WAIT_I -> outputs cleared same cycle; after release, counters 0 and dreq served first in a tie.
REQ-042 Store with wdata 0x12345678, wmask SIZE_W -> mreq fields match exactly; dresp_valid on completion.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared types for the fetch/data memory port arbiter.
// Holds the arbiter state encoding, grant-owner type, access-size encoding
// and the data-stage request/response bundles used around the arbiter.
package mem_port_arbiter_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {SIZE_B = 2'd0, SIZE_H = 2'd1, SIZE_W = 2'd2} mem_size_t;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_WAIT_I = 2'd1;
  localparam arb_state_t ST_WAIT_D = 2'd2;
  typedef enum logic {GRANT_I = 1'b0, GRANT_D = 1'b1} grant_t;
  typedef struct packed {
    logic                valid;
    logic                wen;
    logic [XLEN_DEF-1:0] addr;
    logic [XLEN_DEF-1:0] wdata;
    mem_size_t           wmask;
  } dreq_t;
  typedef struct packed {
    logic                valid;
    logic [XLEN_DEF-1:0] rdata;
  } dresp_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between fetch and data.
// Ports: clk/rst_n (async active-low); ireq_* fetch request, iresp_* fetch data;
// dreq_* load/store request, dresp_* completion; mreq_*/mresp_* shared memory;
// err_unexpected_resp sticky stray-response flag; icount/dcount accepted commands.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ireq_valid,
  output logic             ireq_ready,
  input  logic [XLEN-1:0]  ireq_addr,
  output logic             iresp_valid,
  output logic [XLEN-1:0]  iresp_rdata,
  input  logic             dreq_valid,
  output logic             dreq_ready,
  input  logic             dreq_wen,
  input  logic [XLEN-1:0]  dreq_addr,
  input  logic [XLEN-1:0]  dreq_wdata,
  input  logic [1:0]       dreq_wmask,
  output logic             dresp_valid,
  output logic [XLEN-1:0]  dresp_rdata,
  output logic             mreq_valid,
  output logic             mreq_wen,
  output logic [XLEN-1:0]  mreq_addr,
  output logic [XLEN-1:0]  mreq_wdata,
  output logic [1:0]       mreq_wmask,
  input  logic             mreq_ready,
  input  logic             mresp_valid,
  input  logic [XLEN-1:0]  mresp_rdata,
  output logic             err_unexpected_resp,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
);
  arb_state_t state;
  grant_t     last_grant;
  logic       idle;
  logic       sel_d;
  logic       accept;
  assign idle = state == ST_IDLE;
  // Data wins when it is alone or when fetch was granted last; re-evaluated every idle cycle.
  assign sel_d = dreq_valid & (~ireq_valid | (last_grant == GRANT_I));
  // Gating with rst_n keeps every handshake output low while reset is held.
  assign mreq_valid  = rst_n & idle & (ireq_valid | dreq_valid);
  assign mreq_wen    = idle & sel_d & dreq_wen;
  assign mreq_addr   = sel_d ? dreq_addr : ireq_addr;
  assign mreq_wdata  = dreq_wdata;
  assign mreq_wmask  = sel_d ? dreq_wmask : SIZE_W;
  assign accept      = mreq_valid & mreq_ready;
  assign ireq_ready  = accept & ~sel_d;
  assign dreq_ready  = accept & sel_d;
  assign iresp_valid = rst_n & (state == ST_WAIT_I) & mresp_valid;
  assign dresp_valid = rst_n & (state == ST_WAIT_D) & mresp_valid;
  assign iresp_rdata = mresp_rdata;
  assign dresp_rdata = mresp_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      last_grant          <= GRANT_I;
      icount              <= '0;
      dcount              <= '0;
      err_unexpected_resp <= 1'b0;
    end else if (idle) begin
      if (mresp_valid) err_unexpected_resp <= 1'b1;
      if (accept) begin
        state      <= sel_d ? ST_WAIT_D : ST_WAIT_I;
        last_grant <= sel_d ? GRANT_D : GRANT_I;
        if (sel_d) dcount <= dcount + CNT_W'(1);
        else       icount <= icount + CNT_W'(1);
      end
    end else if (mresp_valid) begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  logic             clk = 0;
  logic             rst_n = 0;
  logic             ireq_valid = 0, ireq_ready;
  logic [XLEN-1:0]  ireq_addr = 0;
  logic             iresp_valid;
  logic [XLEN-1:0]  iresp_rdata;
  logic             dreq_valid = 0, dreq_ready, dreq_wen = 0;
  logic [XLEN-1:0]  dreq_addr = 0, dreq_wdata = 0;
  logic [1:0]       dreq_wmask = 0;
  logic             dresp_valid;
  logic [XLEN-1:0]  dresp_rdata;
  logic             mreq_valid, mreq_wen;
  logic [XLEN-1:0]  mreq_addr, mreq_wdata;
  logic [1:0]       mreq_wmask;
  logic             mreq_ready = 0, mresp_valid = 0;
  logic [XLEN-1:0]  mresp_rdata = 0;
  logic             err_unexpected_resp;
  logic [CNT_W-1:0] icount, dcount;
  int n_cmp = 0, n_bad = 0;
  int outq[$];
  int last_owner = 1;
  int ic = 0, dc = 0;
  bit err = 0;

  mem_port_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
    .iresp_valid(iresp_valid), .iresp_rdata(iresp_rdata),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_wen(dreq_wen),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata), .dreq_wmask(dreq_wmask),
    .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata),
    .mreq_valid(mreq_valid), .mreq_wen(mreq_wen), .mreq_addr(mreq_addr),
    .mreq_wdata(mreq_wdata), .mreq_wmask(mreq_wmask), .mreq_ready(mreq_ready),
    .mresp_valid(mresp_valid), .mresp_rdata(mresp_rdata),
    .err_unexpected_resp(err_unexpected_resp), .icount(icount), .dcount(dcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_regs();
    check("err", err_unexpected_resp, err);
    check("icount", icount, ic % (1 << CNT_W));
    check("dcount", dcount, dc % (1 << CNT_W));
    check("resp_excl", iresp_valid & dresp_valid, 0);
  endtask

  task automatic step(input bit iv, input bit dv, input bit dw, input bit [1:0] dm,
                      input bit mr, input bit mrv, input logic [31:0] ia,
                      input logic [31:0] da, input logic [31:0] dwd, input logic [31:0] mrd);
    bit pick_d, any;
    int own;
    @(negedge clk);
    ireq_valid = iv; dreq_valid = dv; dreq_wen = dw; dreq_wmask = dm;
    mreq_ready = mr; mresp_valid = mrv; ireq_addr = ia; dreq_addr = da;
    dreq_wdata = dwd; mresp_rdata = mrd;
    #1;
    check_regs();
    if (outq.size() == 0) begin
      any = iv | dv;
      pick_d = dv && (!iv || last_owner == 1);
      check("mreq_valid", mreq_valid, any);
      check("ireq_ready", ireq_ready, any && mr && !pick_d);
      check("dreq_ready", dreq_ready, mr && pick_d);
      check("mreq_wen", mreq_wen, pick_d && dw);
      check("iresp_idle", iresp_valid, 0);
      check("dresp_idle", dresp_valid, 0);
      if (any) check("mreq_addr", mreq_addr, pick_d ? da : ia);
      if (pick_d) begin
        check("mreq_wdata", mreq_wdata, dwd);
        check("mreq_wmask", mreq_wmask, dm);
      end
      if (mrv) err = 1;
      if (any && mr) begin
        own = pick_d ? 2 : 1;
        outq.push_back(own);
        last_owner = own;
        if (pick_d) dc++;
        else ic++;
      end
    end else begin
      own = outq[0];
      check("mreq_valid_wait", mreq_valid, 0);
      check("ireq_ready_wait", ireq_ready, 0);
      check("dreq_ready_wait", dreq_ready, 0);
      check("iresp_valid", iresp_valid, mrv && own == 1);
      check("dresp_valid", dresp_valid, mrv && own == 2);
      if (mrv) begin
        if (own == 1) check("iresp_rdata", iresp_rdata, mrd);
        else check("dresp_rdata", dresp_rdata, mrd);
        void'(outq.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    ireq_valid = 1; dreq_valid = 1; mreq_ready = 1; mresp_valid = 1;
    #2 rst_n = 0;
    #1;
    check("rst_mreq_valid", mreq_valid, 0);
    check("rst_ireq_ready", ireq_ready, 0);
    check("rst_dreq_ready", dreq_ready, 0);
    check("rst_iresp_valid", iresp_valid, 0);
    check("rst_dresp_valid", dresp_valid, 0);
    check("rst_err", err_unexpected_resp, 0);
    check("rst_icount", icount, 0);
    check("rst_dcount", dcount, 0);
    ireq_valid = 0; dreq_valid = 0; mreq_ready = 0; mresp_valid = 0;
    @(negedge clk);
    rst_n = 1;
    outq.delete(); last_owner = 1; ic = 0; dc = 0; err = 0;
  endtask

  initial begin
    do_reset();
    // single load, response two cycles after acceptance
    step(0, 1, 0, 2'd2, 1, 0, 0, 32'h100, 0, 0);
    step(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2'd2, 0, 1, 0, 0, 0, 32'hDEADBEEF);
    step(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    // both valid from reset: D, I, D, I alternate
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 2'd2, 1, 0, 32'h1000 + i, 32'h2000 + i, 0, 0);
      step(1, 1, 0, 2'd2, 1, 1, 0, 0, 0, 32'hA0 + i);
    end
    step(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    // stalled memory, then data drops before being accepted
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 0, 2'd2, 0, 0, 32'h40, 32'h80, 0, 0);
    step(1, 0, 0, 2'd2, 1, 0, 32'h40, 32'h80, 0, 0);
    step(0, 0, 0, 2'd2, 0, 1, 0, 0, 0, 32'h55);
    // stray response while idle is sticky
    step(0, 0, 0, 2'd2, 0, 1, 0, 0, 0, 32'h77);
    step(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    // word store
    do_reset();
    step(0, 1, 1, 2'd2, 1, 0, 0, 32'h300, 32'h12345678, 0);
    step(0, 0, 0, 2'd2, 0, 1, 0, 0, 0, 0);
    // reset during an outstanding fetch; its late response is stray
    do_reset();
    step(1, 0, 0, 2'd2, 1, 0, 32'h500, 0, 0, 0);
    step(0, 0, 0, 2'd2, 0, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 1, 0, 2'd2, 1, 1, 32'h600, 32'h700, 0, 32'h99);
    step(0, 0, 0, 2'd2, 0, 1, 0, 0, 0, 32'h98);
    // random traffic, counters wrap at 2^CNT_W
    do_reset();
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, 1'($urandom),
           2'($urandom_range(0, 2)), $urandom_range(0, 9) < 6,
           outq.size() != 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 99) < 2,
           $urandom, $urandom, $urandom, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
